rr_prio_encoder: RTL and testbench

RR_PRIO_ENCODER -- requirements
Module: rr_prio_encoder

---
 rtl/prio_pkg.sv | 19 +
 rtl/prio_pick.sv | 31 +++
 rtl/rr_prio_encoder.sv | 140 ++++++++++++++
 tb/tb_rr_prio_encoder.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/prio_pkg.sv
// Shared types and encodings for the round-robin / fixed priority encoder.
// Holds the FSM state type, the mode encoding and the picker direction.
// Pure declarations, no logic.
package prio_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Arbitration mode as presented on the mode port
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Search direction for the bit picker
  localparam logic DIR_LOW  = 1'b0;
  localparam logic DIR_HIGH = 1'b1;

endpackage

// File: rtl/prio_pick.sv
// Finds the lowest or highest set bit of a vector.
// Latency: purely combinational.
// Backpressure: none, no state.
module prio_pick
  import prio_pkg::*;
#(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] vec_i,
  input  logic         dir_i,
  output logic         found_o,
  output logic [W-1:0] idx_o
);

  // Scan in the direction opposite to the wanted end so the last hit wins
  always_comb begin
    found_o = |vec_i;
    idx_o   = '0;
    if (dir_i == DIR_HIGH) begin
      for (int i = 0; i < N; i++) begin
        if (vec_i[i]) idx_o = W'(i);
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (vec_i[i]) idx_o = W'(i);
      end
    end
  end

endmodule

// File: rtl/rr_prio_encoder.sv
// Grant arbiter over N requesters: fixed (highest index) or round-robin priority.
// Latency: winner appears one cycle after a request; back-to-back grants on ack.
// Backpressure: grant held until ack, withdrawn if the granted request drops.
module rr_prio_encoder
  import prio_pkg::*;
#(
  parameter int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         mode,
  input  logic         ack,
  output logic         gnt_valid,
  output logic [W-1:0] gnt_idx,
  output logic [N-1:0] gnt_onehot
);

  localparam logic [N-1:0] ONE_HOT_0 = N'(1);
  localparam logic [W-1:0] LAST_IDX  = W'(N - 1);

  state_t         state_q;
  logic [W-1:0]   ptr_q;
  logic [W-1:0]   ptr_d;
  logic           gnt_valid_q;
  logic [W-1:0]   gnt_idx_q;
  logic [N-1:0]   gnt_onehot_q;

  logic           accept;
  logic [N-1:0]   cand_req;
  logic [N-1:0]   cand_masked;
  logic           full_dir;
  logic           full_found;
  logic [W-1:0]   full_idx;
  logic           masked_found;
  logic [W-1:0]   masked_idx;
  logic           win_found;
  logic [W-1:0]   win_idx;
  logic [N-1:0]   win_onehot;

  // Candidate set and pointer for the next selection; on ack the granted
  // channel is excluded and the pointer moves past it so the next winner
  // is available in the same cycle without a bubble
  always_comb begin
    accept   = (state_q == GRANT) && ack;
    ptr_d    = ptr_q;
    cand_req = req;
    if (accept) begin
      ptr_d              = (gnt_idx_q == LAST_IDX) ? '0 : gnt_idx_q + W'(1);
      cand_req[gnt_idx_q] = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      cand_masked[i] = cand_req[i] && (i >= int'(ptr_d));
    end
    full_dir = (mode == MODE_FIXED) ? DIR_HIGH : DIR_LOW;
  end

  prio_pick #(.N(N), .W(W)) u_pick_masked (
    .vec_i   (cand_masked),
    .dir_i   (DIR_LOW),
    .found_o (masked_found),
    .idx_o   (masked_idx)
  );

  prio_pick #(.N(N), .W(W)) u_pick_full (
    .vec_i   (cand_req),
    .dir_i   (full_dir),
    .found_o (full_found),
    .idx_o   (full_idx)
  );

  // Winner: round-robin prefers the segment at/above ptr, else wraps around
  always_comb begin
    win_found = full_found;
    if (mode == MODE_RR && masked_found) begin
      win_idx = masked_idx;
    end else begin
      win_idx = full_idx;
    end
    win_onehot = ONE_HOT_0 << win_idx;
  end

  // Arbitration FSM with registered grant outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      gnt_valid_q  <= 1'b0;
      gnt_idx_q    <= '0;
      gnt_onehot_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      case (state_q)
        IDLE: begin
          if (win_found) begin
            state_q      <= GRANT;
            gnt_valid_q  <= 1'b1;
            gnt_idx_q    <= win_idx;
            gnt_onehot_q <= win_onehot;
          end else begin
            gnt_valid_q  <= 1'b0;
            gnt_idx_q    <= '0;
            gnt_onehot_q <= '0;
          end
        end
        GRANT: begin
          if (ack) begin
            if (win_found) begin
              gnt_idx_q    <= win_idx;
              gnt_onehot_q <= win_onehot;
            end else begin
              state_q      <= IDLE;
              gnt_valid_q  <= 1'b0;
              gnt_idx_q    <= '0;
              gnt_onehot_q <= '0;
            end
          end else if (!req[gnt_idx_q]) begin
            // Requester gave up before being served
            state_q      <= IDLE;
            gnt_valid_q  <= 1'b0;
            gnt_idx_q    <= '0;
            gnt_onehot_q <= '0;
          end
        end
        default: begin
          state_q      <= IDLE;
          gnt_valid_q  <= 1'b0;
          gnt_idx_q    <= '0;
          gnt_onehot_q <= '0;
        end
      endcase
    end
  end

  assign gnt_valid  = gnt_valid_q;
  assign gnt_idx    = gnt_idx_q;
  assign gnt_onehot = gnt_onehot_q;

endmodule

// File: tb/tb_rr_prio_encoder.sv
// Directed bench for rr_prio_encoder with an N=8 and an N=5 instance.
// Inputs change 1 time unit after each rising edge; outputs are sampled there too.
// Each task checks its own scenario against hand-computed values.
module tb_rr_prio_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req8;
  logic       mode8;
  logic       ack8;
  logic       vld8;
  logic [2:0] idx8;
  logic [7:0] oh8;
  logic [4:0] req5;
  logic       mode5;
  logic       ack5;
  logic       vld5;
  logic [2:0] idx5;
  logic [4:0] oh5;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rr_prio_encoder #(.N(8)) dut8 (
    .clk        (clk),
    .rst        (rst),
    .req        (req8),
    .mode       (mode8),
    .ack        (ack8),
    .gnt_valid  (vld8),
    .gnt_idx    (idx8),
    .gnt_onehot (oh8)
  );

  rr_prio_encoder #(.N(5)) dut5 (
    .clk        (clk),
    .rst        (rst),
    .req        (req5),
    .mode       (mode5),
    .ack        (ack5),
    .gnt_valid  (vld5),
    .gnt_idx    (idx5),
    .gnt_onehot (oh5)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; req8 = 8'hFF; mode8 = 1'b0; ack8 = 1'b0;
    req5 = 5'h1F; mode5 = 1'b0; ack5 = 1'b0;
    tick();
    n_checks++;
    if ({vld8, idx8, oh8} !== 12'h000) begin
      n_fail++; $display("FAIL reset_n8: got vld=%0b idx=%0d oh=%b, want 0/0/0", vld8, idx8, oh8);
    end
    n_checks++;
    if ({vld5, idx5, oh5} !== 9'h000) begin
      n_fail++; $display("FAIL reset_n5: got vld=%0b idx=%0d oh=%b, want 0/0/0", vld5, idx5, oh5);
    end
    rst = 1'b0; req8 = 8'h00; req5 = 5'h00;
    tick();
    n_checks++;
    if (vld8 !== 1'b0 || idx8 !== 3'd0 || oh8 !== 8'h00) begin
      n_fail++; $display("FAIL idle_noreq: got vld=%0b idx=%0d oh=%b, want 0/0/0", vld8, idx8, oh8);
    end
  endtask

  task automatic test_fixed;
    mode8 = 1'b0; req8 = 8'b1010_0110; ack8 = 1'b0;
    tick();
    n_checks++;
    if (vld8 !== 1'b1 || idx8 !== 3'd7 || oh8 !== 8'h80) begin
      n_fail++; $display("FAIL fixed_first: got vld=%0b idx=%0d oh=%b, want 1/7/10000000", vld8, idx8, oh8);
    end
    // ack together with bit 7 dropping: ack wins, next highest is 5
    ack8 = 1'b1; req8 = 8'b0010_0110;
    tick();
    n_checks++;
    if (vld8 !== 1'b1 || idx8 !== 3'd5 || oh8 !== 8'h20) begin
      n_fail++; $display("FAIL fixed_next: got vld=%0b idx=%0d oh=%b, want 1/5/00100000", vld8, idx8, oh8);
    end
    // higher request and a mode flip must not disturb the held grant
    ack8 = 1'b0; req8 = 8'b1110_0110; mode8 = 1'b1;
    tick();
    tick();
    n_checks++;
    if (vld8 !== 1'b1 || idx8 !== 3'd5 || oh8 !== 8'h20) begin
      n_fail++; $display("FAIL fixed_hold: got vld=%0b idx=%0d oh=%b, want 1/5/00100000", vld8, idx8, oh8);
    end
    ack8 = 1'b1; req8 = 8'h00; mode8 = 1'b0;
    tick();
    n_checks++;
    if (vld8 !== 1'b0 || oh8 !== 8'h00) begin
      n_fail++; $display("FAIL fixed_to_idle: got vld=%0b oh=%b, want 0/00000000", vld8, oh8);
    end
    ack8 = 1'b0;
  endtask

  task automatic test_back_to_back;
    rst = 1'b1;
    tick();
    rst = 1'b0; mode8 = 1'b1; req8 = 8'hFF; ack8 = 1'b0;
    tick();
    n_checks++;
    if (vld8 !== 1'b1 || idx8 !== 3'd0) begin
      n_fail++; $display("FAIL rr_start: got vld=%0b idx=%0d, want 1/0", vld8, idx8);
    end
    ack8 = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      logic [2:0] exp_idx;
      exp_idx = 3'(k % 8);
      tick();
      n_checks++;
      if (vld8 !== 1'b1 || idx8 !== exp_idx || oh8 !== (8'h01 << exp_idx)) begin
        n_fail++; $display("FAIL rr_seq[%0d]: got vld=%0b idx=%0d oh=%b, want 1/%0d", k, vld8, idx8, oh8, exp_idx);
      end
    end
    ack8 = 1'b0;
  endtask

  task automatic test_wrap;
    rst = 1'b1;
    tick();
    rst = 1'b0; mode8 = 1'b1; req8 = 8'h80; ack8 = 1'b0;
    tick();
    n_checks++;
    if (vld8 !== 1'b1 || idx8 !== 3'd7) begin
      n_fail++; $display("FAIL wrap_grant7: got vld=%0b idx=%0d, want 1/7", vld8, idx8);
    end
    ack8 = 1'b1; req8 = 8'h00;
    tick();
    ack8 = 1'b0; req8 = 8'b1000_0010;
    tick();
    n_checks++;
    if (vld8 !== 1'b1 || idx8 !== 3'd1 || oh8 !== 8'h02) begin
      n_fail++; $display("FAIL wrap_ptr0: got vld=%0b idx=%0d oh=%b, want 1/1/00000010", vld8, idx8, oh8);
    end
  endtask

  task automatic test_withdraw;
    // granted 1 with ptr 0; ack moves ptr to 2 and hands over to 3
    ack8 = 1'b1; req8 = 8'h08;
    tick();
    n_checks++;
    if (vld8 !== 1'b1 || idx8 !== 3'd3) begin
      n_fail++; $display("FAIL withdraw_grant3: got vld=%0b idx=%0d, want 1/3", vld8, idx8);
    end
    ack8 = 1'b0; req8 = 8'h06;
    tick();
    n_checks++;
    if (vld8 !== 1'b0 || idx8 !== 3'd0 || oh8 !== 8'h00) begin
      n_fail++; $display("FAIL withdraw_drop: got vld=%0b idx=%0d oh=%b, want 0/0/0", vld8, idx8, oh8);
    end
    tick();
    n_checks++;
    if (vld8 !== 1'b1 || idx8 !== 3'd2) begin
      n_fail++; $display("FAIL withdraw_ptr_kept: got vld=%0b idx=%0d, want 1/2", vld8, idx8);
    end
    // ack on 2 -> ptr 3; a further ack while idle must be ignored
    ack8 = 1'b1; req8 = 8'h00;
    tick();
    tick();
    n_checks++;
    if (vld8 !== 1'b0) begin
      n_fail++; $display("FAIL idle_ack: got vld=%0b, want 0", vld8);
    end
    ack8 = 1'b0; req8 = 8'h0A;
    tick();
    n_checks++;
    if (vld8 !== 1'b1 || idx8 !== 3'd3) begin
      n_fail++; $display("FAIL idle_ack_ptr: got vld=%0b idx=%0d, want 1/3", vld8, idx8);
    end
  endtask

  task automatic test_mid_reset;
    rst = 1'b1; req8 = 8'hFF; ack8 = 1'b0;
    tick();
    n_checks++;
    if (vld8 !== 1'b0 || idx8 !== 3'd0 || oh8 !== 8'h00) begin
      n_fail++; $display("FAIL midreset: got vld=%0b idx=%0d oh=%b, want 0/0/0", vld8, idx8, oh8);
    end
    rst = 1'b0; mode8 = 1'b1; req8 = 8'h10;
    tick();
    n_checks++;
    if (vld8 !== 1'b1 || idx8 !== 3'd4 || oh8 !== 8'h10) begin
      n_fail++; $display("FAIL post_reset: got vld=%0b idx=%0d oh=%b, want 1/4/00010000", vld8, idx8, oh8);
    end
    req8 = 8'h00;
  endtask

  task automatic test_n5;
    mode5 = 1'b1; req5 = 5'b10000; ack5 = 1'b0;
    tick();
    n_checks++;
    if (vld5 !== 1'b1 || idx5 !== 3'd4 || oh5 !== 5'b10000) begin
      n_fail++; $display("FAIL n5_grant4: got vld=%0b idx=%0d oh=%b, want 1/4/10000", vld5, idx5, oh5);
    end
    ack5 = 1'b1; req5 = 5'b00000;
    tick();
    ack5 = 1'b0; req5 = 5'b10001;
    tick();
    n_checks++;
    if (vld5 !== 1'b1 || idx5 !== 3'd0 || oh5 !== 5'b00001) begin
      n_fail++; $display("FAIL n5_wrap: got vld=%0b idx=%0d oh=%b, want 1/0/00001", vld5, idx5, oh5);
    end
    ack5 = 1'b1; req5 = 5'b11111;
    for (int k = 1; k <= 7; k++) begin
      logic [2:0] exp_idx;
      exp_idx = 3'(k % 5);
      tick();
      n_checks++;
      if (vld5 !== 1'b1 || idx5 !== exp_idx || idx5 > 3'd4) begin
        n_fail++; $display("FAIL n5_seq[%0d]: got vld=%0b idx=%0d, want 1/%0d", k, vld5, idx5, exp_idx);
      end
    end
    ack5 = 1'b0; req5 = 5'b00000;
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_back_to_back();
    test_wrap();
    test_withdraw();
    test_mid_reset();
    test_n5();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
